seg7_scan_decoder: RTL and testbench
====================================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive identical synchronized samples required before a display state is accepted; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 AN  input  4  anode lines, active-low; AN[i]=0 selects digit i.
REQ-005 DISPLAY  input  7  segment lines, active-low; bit0=a through bit6=g.
REQ-006 DIGITS  output  16  captured hex values {digit3,digit2,digit1,digit0}; digit i occupies bits [4i+3:4i].
REQ-007 VALID  output  4  VALID[i]=1 once digit i has been captured since reset.
REQ-008 UPD  output  1  one-cycle pulse on each successful capture.
REQ-009 UPD_IDX  output  2  index of the digit written by the current UPD pulse; holds its last value otherwise.
REQ-010 ERR  output  1  one-cycle pulse when an accepted state is illegal.
REQ-011 ERR_COUNT  output  8  number of ERR pulses since reset, saturating.

Function
REQ-012 AN and DISPLAY SHALL each pass through a two-flop synchronizer before any other use.
REQ-013 The block SHALL compare each synchronized 11-bit sample {AN,DISPLAY} with the previous synchronized sample.
REQ-014 FSM states SHALL be: SETTLE, meaning the sample is counting toward stability, and HOLD, meaning the sample has been accepted and the block waits for a change.
REQ-015 In SETTLE, when the sample equals the previous sample, the 4-bit stability counter SHALL increment; when the counter reaches STABLE_CYCLES, the block SHALL perform an accept and move to HOLD.
REQ-016 Any sample change, in either state, SHALL set the counter to 1 and the state to SETTLE, with no accept in that cycle; a change takes priority over a coincident accept.
REQ-017 In HOLD, an unchanged sample SHALL produce no further accepts, so each stable state is accepted exactly once.
REQ-018 Accept with AN=4'b1111 (blank) SHALL change no output and SHALL NOT flag an error.
REQ-019 Accept with exactly one AN bit low and DISPLAY in the decode table SHALL write the decoded value to that digit, set its VALID bit, pulse UPD, and drive UPD_IDX to the digit index, all on the same edge.
REQ-020 Decode table (DISPLAY hex -> value): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F.
REQ-021 Accept with more than one AN bit low, or with one AN bit low and DISPLAY not in the table, SHALL pulse ERR, increment ERR_COUNT, and leave DIGITS, VALID and UPD unchanged.
REQ-022 ERR_COUNT SHALL saturate at 255; ERR SHALL still pulse on an error while the count is saturated.
REQ-023 Latency: with the pins held constant, UPD or ERR SHALL assert exactly STABLE_CYCLES+2 cycles after the first rising edge that samples the new pin value.
REQ-024 Returning to a previously accepted state after any intervening change SHALL produce a new accept.
REQ-025 UPD and ERR SHALL never be high in the same cycle.

Reset
REQ-026 Asserting rst SHALL immediately clear DIGITS, VALID, UPD, UPD_IDX, ERR, ERR_COUNT and the stability counter, and SHALL force the state to SETTLE.
REQ-027 Reset SHALL set the synchronizer and previous-sample registers to all-ones (blank), so that no capture occurs from reset values.
REQ-028 Reset asserted mid-settle SHALL abort the pending accept; after release, a full STABLE_CYCLES+2 interval is required before the next accept.

Verification
REQ-029 STABLE_CYCLES=4, AN=1110, DISPLAY=0x24 held: UPD at cycle 6, UPD_IDX=0, DIGITS[3:0]=2, VALID=0001, with exactly one UPD pulse over the next 20 cycles.
REQ-030 Scan AN 1110/1101/1011/0111 with DISPLAY 0x79/0x30/0x12/0x0E, each held 8 cycles: DIGITS=16'hF531, VALID=1111, four UPD pulses.
REQ-031 AN=1101 with DISPLAY=0x24, except that DISPLAY toggles to 0x30 for 1 cycle every 3 cycles: no UPD and no ERR during the toggling; after the toggling stops and DISPLAY is held at 0x24, UPD fires with DIGITS[7:4]=2.
REQ-032 AN=1100 with DISPLAY=0x40 held, then AN=1110 with DISPLAY=0x7F held: ERR_COUNT=2, DIGITS unchanged, no UPD; 300 alternating illegal states -> ERR_COUNT=255.
REQ-033 Assert rst for 1 cycle, 2 cycles after applying AN=1110 with DISPLAY=0x00 (before the accept would occur): all outputs read 0, and UPD first appears 6 cycles after release.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digit values from a multiplexed active-low 7-segment scan bus
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [6:0]  DISPLAY,
    output logic [15:0] DIGITS,
    output logic [3:0]  VALID,
    output logic        UPD,
    output logic [1:0]  UPD_IDX,
    output logic        ERR,
    output logic [7:0]  ERR_COUNT
);
    typedef enum logic {SETTLE, HOLD} state_t;
    state_t      state;
    logic [10:0] s1, s2, prev;
    logic [3:0]  cnt;
    logic [3:0]  sel;
    logic        hit;
    logic [3:0]  val;
    logic [1:0]  idx;
    logic        same;
    assign sel  = ~s2[10:7];
    assign same = s2 == prev;
    assign idx  = sel[3] ? 2'd3 : sel[2] ? 2'd2 : sel[1] ? 2'd1 : 2'd0;
    always_comb begin
        hit = 1'b1;
        val = 4'h0;
        case (s2[6:0])
            7'h40: val = 4'h0;
            7'h79: val = 4'h1;
            7'h24: val = 4'h2;
            7'h30: val = 4'h3;
            7'h19: val = 4'h4;
            7'h12: val = 4'h5;
            7'h02: val = 4'h6;
            7'h78: val = 4'h7;
            7'h00: val = 4'h8;
            7'h10: val = 4'h9;
            7'h08: val = 4'hA;
            7'h03: val = 4'hB;
            7'h46: val = 4'hC;
            7'h21: val = 4'hD;
            7'h06: val = 4'hE;
            7'h0E: val = 4'hF;
            default: hit = 1'b0;
        endcase
    end
    // the counter holds at STABLE_CYCLES and the accept fires on the next identical sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= '1;
            s2        <= '1;
            prev      <= '1;
            state     <= SETTLE;
            cnt       <= '0;
            DIGITS    <= '0;
            VALID     <= '0;
            UPD       <= 1'b0;
            UPD_IDX   <= '0;
            ERR       <= 1'b0;
            ERR_COUNT <= '0;
        end else begin
            s1   <= {AN, DISPLAY};
            s2   <= s1;
            prev <= s2;
            UPD  <= 1'b0;
            ERR  <= 1'b0;
            if (!same) begin
                cnt   <= 4'd1;
                state <= SETTLE;
            end else if (state == SETTLE) begin
                if (cnt == 4'(STABLE_CYCLES)) begin
                    state <= HOLD;
                    if (sel != 4'd0) begin
                        if ($onehot(sel) && hit) begin
                            DIGITS[idx*4 +: 4] <= val;
                            VALID[idx]         <= 1'b1;
                            UPD                <= 1'b1;
                            UPD_IDX            <= idx;
                        end else begin
                            ERR <= 1'b1;
                            if (ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
                        end
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: run-length behavioural model plus directed scenarios for seg7_scan_decoder
module tb_seg7_scan_decoder;
    localparam int S = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  AN = 4'hF;
    logic [6:0]  DISPLAY = 7'h7F;
    logic [15:0] DIGITS;
    logic [3:0]  VALID;
    logic        UPD;
    logic [1:0]  UPD_IDX;
    logic        ERR;
    logic [7:0]  ERR_COUNT;
    int errors = 0, checks = 0, upd_cnt = 0, err_pulses = 0;
    logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_digits;
    logic [3:0]  m_valid;
    logic        m_upd, m_err, fresh;
    logic [1:0]  m_idx;
    logic [7:0]  m_ec;
    logic [10:0] last;
    int          run;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .AN(AN), .DISPLAY(DISPLAY), .DIGITS(DIGITS), .VALID(VALID),
        .UPD(UPD), .UPD_IDX(UPD_IDX), .ERR(ERR), .ERR_COUNT(ERR_COUNT)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    // A pin value held for S+3 consecutive sampling edges is accepted exactly once
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_digits <= '0; m_valid <= '0; m_upd <= 1'b0; m_err <= 1'b0;
            m_idx <= '0; m_ec <= '0; run <= 0; fresh <= 1'b1; last <= '1;
        end else begin
            int r, n, p;
            logic found;
            logic [3:0] v;
            logic [10:0] cur;
            cur = {AN, DISPLAY};
            r = (!fresh && cur == last) ? run + 1 : 1;
            run <= r; last <= cur; fresh <= 1'b0; m_upd <= 1'b0; m_err <= 1'b0;
            if (r == S + 3 && AN != 4'hF) begin
                n = 0; p = 0; found = 1'b0; v = 4'h0;
                for (int i = 0; i < 4; i++) if (!AN[i]) begin n++; p = i; end
                for (int j = 0; j < 16; j++) if (codes[j] == DISPLAY) begin found = 1'b1; v = 4'(j); end
                if (n == 1 && found) begin
                    m_digits[p*4 +: 4] <= v;
                    m_valid[p] <= 1'b1;
                    m_upd <= 1'b1;
                    m_idx <= 2'(p);
                end else begin
                    m_err <= 1'b1;
                    if (m_ec != 8'hFF) m_ec <= m_ec + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("digits", DIGITS, m_digits);
        chk("valid", VALID, m_valid);
        chk("upd", UPD, m_upd);
        chk("upd_idx", UPD_IDX, m_idx);
        chk("err", ERR, m_err);
        chk("err_count", ERR_COUNT, m_ec);
        chk("upd_err_excl", UPD & ERR, 0);
        if (UPD) upd_cnt++;
        if (ERR) err_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set(input logic [3:0] a, input logic [6:0] d);
        AN = a;
        DISPLAY = d;
    endtask

    task automatic wait_upd(output int k);
        k = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (UPD) begin k = i; break; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int k, u0, e0;
        logic [15:0] dsave;
        step(3);
        chk("reset_digits", DIGITS, 0);
        chk("reset_valid", VALID, 0);
        chk("reset_errcnt", ERR_COUNT, 0);
        rst = 1'b0;
        step(4);
        // single digit capture latency
        set(4'b1110, 7'h24);
        wait_upd(k);
        chk("lat_upd_cycle", k, 6);
        chk("lat_digit0", DIGITS[3:0], 4'h2);
        chk("lat_valid", VALID, 4'b0001);
        chk("lat_idx", UPD_IDX, 0);
        u0 = upd_cnt;
        step(20);
        chk("lat_single_pulse", upd_cnt - u0, 0);
        // four-digit scan
        u0 = upd_cnt;
        set(4'b1110, 7'h79); step(8);
        set(4'b1101, 7'h30); step(8);
        set(4'b1011, 7'h12); step(8);
        set(4'b0111, 7'h0E); step(8);
        chk("scan_digits", DIGITS, 16'hF531);
        chk("scan_valid", VALID, 4'hF);
        chk("scan_upds", upd_cnt - u0, 4);
        // glitching segments never settle
        u0 = upd_cnt; e0 = err_pulses;
        for (int i = 0; i < 10; i++) begin
            set(4'b1101, 7'h24); step(2);
            set(4'b1101, 7'h30); step(1);
        end
        chk("glitch_no_upd", upd_cnt - u0, 0);
        chk("glitch_no_err", err_pulses - e0, 0);
        set(4'b1101, 7'h24); step(10);
        chk("glitch_settled_upd", upd_cnt - u0, 1);
        chk("glitch_digit1", DIGITS[7:4], 4'h2);
        // illegal states and error saturation
        do_reset();
        set(4'b1011, 7'h12); step(10);
        dsave = DIGITS;
        chk("ill_pre_digits", dsave, 16'h0500);
        u0 = upd_cnt; e0 = err_pulses;
        set(4'b1100, 7'h40); step(10);
        set(4'b1110, 7'h7F); step(10);
        chk("ill_errcnt2", ERR_COUNT, 2);
        chk("ill_digits", DIGITS, dsave);
        chk("ill_no_upd", upd_cnt - u0, 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) set(4'b1100, 7'h40); else set(4'b1110, 7'h7F);
            step(8);
        end
        chk("ill_sat", ERR_COUNT, 255);
        chk("ill_pulses", err_pulses - e0, 302);
        // reset aborts a pending accept
        set(4'b1111, 7'h7F); step(8);
        set(4'b1110, 7'h00); step(2);
        rst = 1'b1;
        #1;
        chk("rst_digits", DIGITS, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_upd", UPD, 0);
        chk("rst_idx", UPD_IDX, 0);
        chk("rst_err", ERR, 0);
        chk("rst_errcnt", ERR_COUNT, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        wait_upd(k);
        chk("rst_upd_cycle", k, 6);
        chk("rst_digit0", DIGITS[3:0], 4'h8);
        step(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
